// File: rtl/pcpi_muldiv_pkg.sv
// pcpi_muldiv_pkg
//   Shared encodings for the RV32M PCPI responder: opcode/funct7 match
//   constants, the funct3 operation enum and the controller state enum.
package pcpi_muldiv_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pcpi_muldiv_iter_core.sv
// muldiv_iter_core
//   Unsigned 1-bit-per-cycle multiply / restoring divide engine.
//   Works on operand magnitudes only; sign handling lives in the top level.
// Ports:
//   clk, resetn   clock, async active-low reset
//   i_start       load operands, clear counter, start iterating
//   i_abort       stop iterating (result is discarded by the caller)
//   i_is_div      1 = divide, 0 = multiply (sampled with i_start)
//   i_a, i_b      multiply: multiplicand / multiplier; divide: dividend / divisor
//   o_busy        iterations in progress
//   o_done        high during the cycle whose edge performs the last iteration
//   o_acc         multiply: 2*XLEN product; divide: {remainder, quotient}
module muldiv_iter_core #(
    parameter int XLEN        = 32,
    parameter int ITER_CYCLES = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [2*XLEN-1:0] o_acc
);

    localparam int              CNT_W    = $clog2(ITER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic             r_is_div;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN:0]    w_mul_sum;
    logic [XLEN:0]    w_div_shift;
    logic [XLEN:0]    w_div_diff;
    logic             w_qbit;
    logic [XLEN-1:0]  w_hi_nxt;
    logic [XLEN-1:0]  w_lo_nxt;

    // Multiply: r_lo starts as the multiplier and is shifted out LSB first
    // while the product fills in from the top.
    // Divide: {r_hi, r_lo} shifts left; r_hi is the partial remainder and
    // quotient bits enter r_lo from the right. The partial remainder stays
    // below the divisor, so bit XLEN of the difference is a clean borrow,
    // including the divide-by-zero case where every quotient bit becomes 1.
    always_comb begin
        w_mul_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        w_qbit      = ~w_div_diff[XLEN];
        if (r_is_div) begin
            w_hi_nxt = w_qbit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
        end else begin
            w_hi_nxt = w_mul_sum[XLEN:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_hi     <= '0;
            r_lo     <= i_is_div ? i_a : i_b;
            r_b      <= i_is_div ? i_b : i_a;
            r_is_div <= i_is_div;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
        end else if (i_abort) begin
            r_busy   <= 1'b0;
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy & (r_cnt == CNT_LAST);
    assign o_acc  = {r_hi, r_lo};

endmodule

// File: rtl/pcpi_muldiv.sv
// pcpi_muldiv
//   PCPI responder for the RV32M group (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   Decodes the instruction, converts operands to magnitudes, runs the
//   iterative core, applies sign correction and holds the result until the
//   next transaction starts. XLEN must be 32 and ITER_CYCLES must equal XLEN.
// Ports:
//   clk, resetn         clock, async active-low reset
//   pcpi_valid          core presents an instruction
//   pcpi_insn           instruction word
//   pcpi_rs1, pcpi_rs2  operand values
//   pcpi_wr             result must be written to rd (held)
//   pcpi_rd             result value (held)
//   pcpi_wait           instruction recognised, busy (combinational)
//   pcpi_ready          one-cycle completion pulse
// Build option:
//   PCPI_MULDIV_EARLY_OUT_EN  divide by zero, signed overflow and multiply by
//                             zero bypass CALC (ready after edge A+2).
//
// state | meaning
// IDLE  | waiting for a matching instruction; latch op and sign info
// CALC  | iterative core running (ITER_CYCLES cycles)
// FIX   | two cycles: sign-correct the raw result, then select/register rd
// DONE  | ready pulse visible; back to IDLE next edge
module pcpi_muldiv
    import pcpi_muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ITER_CYCLES = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);

    state_t              r_state;
    state_t              w_state_nxt;
    op_t                 r_op;
    op_t                 w_op;

    logic                w_match;
    logic                w_is_div;
    logic                w_s1;
    logic                w_s2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_start;
    logic                w_early;
    logic                w_busy;
    logic                w_done;
    logic [2*XLEN-1:0]   w_acc;
    logic [2*XLEN-1:0]   w_fixed;
    logic                w_sel_hi;
    logic                w_unused_insn;

    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_fix_ph;
    logic                r_early;
    logic [2*XLEN-1:0]   r_res;
    logic [XLEN-1:0]     r_rd;
    logic                r_wr;
    logic                r_ready;

    assign w_match  = pcpi_valid & (pcpi_insn[6:0] == OPC_OP) & (pcpi_insn[31:25] == FUNCT7_MULDIV);
    assign w_op     = op_t'(pcpi_insn[14:12]);
    assign w_is_div = pcpi_insn[14];
    assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    always_comb begin
        w_s1   = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & pcpi_rs1[XLEN-1];
        w_s2   = (w_op inside {OP_MULH, OP_DIV, OP_REM}) & pcpi_rs2[XLEN-1];
        w_mag1 = w_s1 ? -pcpi_rs1 : pcpi_rs1;
        w_mag2 = w_s2 ? -pcpi_rs2 : pcpi_rs2;
    end

`ifdef PCPI_MULDIV_EARLY_OUT_EN
    logic [2*XLEN-1:0] w_early_res;

    // Result layout matches the core: {remainder, quotient} or the product.
    always_comb begin
        w_early     = 1'b0;
        w_early_res = '0;
        if (w_is_div) begin
            if (pcpi_rs2 == '0) begin
                w_early     = 1'b1;
                w_early_res = {pcpi_rs1, {XLEN{1'b1}}};
            end else if (!pcpi_insn[12] && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (pcpi_rs2 == '1)) begin
                w_early     = 1'b1;
                w_early_res = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            end
        end else if ((pcpi_rs1 == '0) || (pcpi_rs2 == '0)) begin
            w_early     = 1'b1;
            w_early_res = '0;
        end
    end
`else
    assign w_early = 1'b0;
`endif

    muldiv_iter_core #(
        .XLEN        (XLEN),
        .ITER_CYCLES (ITER_CYCLES)
    ) u_core (
        .clk      (clk),
        .resetn   (resetn),
        .i_start  (w_start),
        .i_abort  (w_busy & ~pcpi_valid),
        .i_is_div (w_is_div),
        .i_a      (w_mag1),
        .i_b      (w_mag2),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_acc    (w_acc)
    );

    // Divide-by-zero quotient must stay all-ones, hence r_neg_q is gated by
    // a non-zero divisor; the remainder always follows the dividend's sign.
    always_comb begin
        if (r_op[2]) begin
            w_fixed = {(r_neg_r ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN]),
                       (r_neg_q ? -w_acc[XLEN-1:0]      : w_acc[XLEN-1:0])};
        end else begin
            w_fixed = r_neg_q ? -w_acc : w_acc;
        end
        w_sel_hi = r_op[2] ? r_op[1] : (r_op[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        pcpi_wait   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_match) begin
                    pcpi_wait   = 1'b1;
                    w_start     = ~w_early;
                    w_state_nxt = w_early ? FIX : CALC;
                end
            end
            CALC: begin
                pcpi_wait = 1'b1;
                if (!pcpi_valid) begin
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                pcpi_wait = 1'b1;
                if (!pcpi_valid) begin
                    w_state_nxt = IDLE;
                end else if (r_fix_ph) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op     <= OP_MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fix_ph <= 1'b0;
            r_early  <= 1'b0;
            r_res    <= '0;
            r_rd     <= '0;
            r_wr     <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Any new request clears a stale write flag, even one we
                    // do not recognise.
                    if (pcpi_valid) begin
                        r_wr <= 1'b0;
                    end
                    if (w_match) begin
                        r_op     <= w_op;
                        r_neg_q  <= (w_s1 ^ w_s2) & (pcpi_rs2 != '0);
                        r_neg_r  <= w_s1;
                        r_fix_ph <= 1'b0;
                        r_early  <= w_early;
`ifdef PCPI_MULDIV_EARLY_OUT_EN
                        r_res    <= w_early_res;
`endif
                    end
                end
                FIX: begin
                    if (pcpi_valid) begin
                        if (!r_fix_ph) begin
                            r_fix_ph <= 1'b1;
                            if (!r_early) begin
                                r_res <= w_fixed;
                            end
                        end else begin
                            r_rd    <= w_sel_hi ? r_res[2*XLEN-1:XLEN] : r_res[XLEN-1:0];
                            r_wr    <= 1'b1;
                            r_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;
    assign pcpi_ready = r_ready;

endmodule

// File: tb/tb_pcpi_muldiv.sv
module tb_pcpi_muldiv;

    logic        clk;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int checks = 0;
    int errors = 0;

    pcpi_muldiv dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = 0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Posedge count from valid-raise to the sample where ready is seen.
    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef PCPI_MULDIV_EARLY_OUT_EN
        if (f3[2]) begin
            if (b == 0) return 3;
            if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 3;
        end else if (a == 0 || b == 0) begin
            return 3;
        end
`endif
        return 35;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          lat;
        int          n;
        bit          seen;
        bit          wait_ok;
        exp = ref_model(f3, a, b);
        lat = exp_latency(f3, a, b);
        @(negedge clk);
        pcpi_insn  = {7'b0000001, 10'($urandom), f3, 5'($urandom), 7'b0110011};
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        #1;
        wait_ok = (pcpi_wait === 1'b1);
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (pcpi_ready === 1'b1) begin
                seen = 1;
            end else begin
                if (pcpi_wait !== 1'b1) wait_ok = 0;
                pcpi_rs1 = $urandom;
                pcpi_rs2 = $urandom;
            end
        end
        chk($sformatf("%s_latency", tag), 32'(n), 32'(lat));
        chk($sformatf("%s_wait_busy", tag), {31'b0, wait_ok}, 32'd1);
        chk($sformatf("%s_rd", tag), pcpi_rd, exp);
        chk($sformatf("%s_wr", tag), {31'b0, pcpi_wr}, 32'd1);
        chk($sformatf("%s_wait_done", tag), {31'b0, pcpi_wait}, 32'd0);
        @(negedge clk);
        pcpi_valid = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("%s_ready_pulse", tag), {31'b0, pcpi_ready}, 32'd0);
        chk($sformatf("%s_rd_hold", tag), pcpi_rd, exp);
        chk($sformatf("%s_wr_hold", tag), {31'b0, pcpi_wr}, 32'd1);
    endtask

    initial begin
        bit          rdy_seen;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'h0;
        pcpi_rs1   = 32'h0;
        pcpi_rs2   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr",    {31'b0, pcpi_wr},    32'd0);
        chk("reset_rd",    pcpi_rd,             32'd0);
        chk("reset_ready", {31'b0, pcpi_ready}, 32'd0);
        chk("reset_wait",  {31'b0, pcpi_wait},  32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(3'd0, 32'd7,        32'd6,        "mul_7x6");
        run_op(3'd1, 32'hFFFFFFFF, 32'd2,        "mulh_m1x2");
        run_op(3'd3, 32'hFFFFFFFF, 32'd2,        "mulhu_m1x2");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2,        "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2,        "rem_m7_2");
        run_op(3'd5, 32'd5,        32'd0,        "divu_by0");
        run_op(3'd7, 32'd5,        32'd0,        "remu_by0");
        run_op(3'd4, 32'hFFFFFFF9, 32'd0,        "div_by0_neg");
        run_op(3'd6, 32'hFFFFFFF9, 32'd0,        "rem_by0_neg");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
        run_op(3'd0, 32'd0,        32'h12345678, "mul_zero");

        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, a, b, $sformatf("rand%0d_f%0d", i, f3));
        end

        // Unrecognised instruction right after a MUL.
        run_op(3'd0, 32'd7, 32'd6, "mul_before_unrec");
        @(negedge clk);
        pcpi_insn  = 32'h00000013;
        pcpi_valid = 1'b1;
        #1;
        chk("unrec_wait", {31'b0, pcpi_wait}, 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0) rdy_seen = 1;
        end
        chk("unrec_no_ready", {31'b0, rdy_seen}, 32'd0);
        chk("unrec_wr", {31'b0, pcpi_wr}, 32'd0);
        @(negedge clk);
        pcpi_valid = 1'b0;

        // Abort in CALC: result registers untouched apart from the start-clear of wr.
        run_op(3'd0, 32'd7, 32'd6, "mul_before_abort");
        @(negedge clk);
        pcpi_insn  = {7'b0000001, 10'd0, 3'd4, 5'd1, 7'b0110011};
        pcpi_rs1   = 32'd1000;
        pcpi_rs2   = 32'd7;
        pcpi_valid = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        pcpi_valid = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (pcpi_ready !== 1'b0) rdy_seen = 1;
        end
        chk("abort_no_ready", {31'b0, rdy_seen}, 32'd0);
        chk("abort_wait", {31'b0, pcpi_wait}, 32'd0);
        chk("abort_rd", pcpi_rd, 32'h0000002A);
        chk("abort_wr", {31'b0, pcpi_wr}, 32'd0);
        run_op(3'd5, 32'd1000, 32'd7, "divu_after_abort");

        // Reset pulse in the middle of CALC.
        @(negedge clk);
        pcpi_insn  = {7'b0000001, 10'd0, 3'd0, 5'd1, 7'b0110011};
        pcpi_rs1   = 32'd5;
        pcpi_rs2   = 32'd5;
        pcpi_valid = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        pcpi_valid = 1'b0;
        resetn     = 1'b0;
        #1;
        chk("midrst_wr",    {31'b0, pcpi_wr},    32'd0);
        chk("midrst_rd",    pcpi_rd,             32'd0);
        chk("midrst_ready", {31'b0, pcpi_ready}, 32'd0);
        chk("midrst_wait",  {31'b0, pcpi_wait},  32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (pcpi_ready !== 1'b0) rdy_seen = 1;
        end
        chk("midrst_no_ready", {31'b0, rdy_seen}, 32'd0);
        run_op(3'd0, 32'd3, 32'd3, "mul_3x3_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
